// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, ExcCodes, SR/Cause field positions
// and the handler mode encoding.
package cp0_pkg;

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int SR_IE_BIT     = 0;
    localparam int SR_EXL_BIT    = 1;
    localparam int SR_IM_LSB     = 10;
    localparam int SR_IM_MSB     = 15;
    localparam int CAUSE_EXC_LSB = 2;
    localparam int CAUSE_EXC_MSB = 6;
    localparam int CAUSE_IP_LSB  = 10;
    localparam int CAUSE_IP_MSB  = 15;
    localparam int CAUSE_BD_BIT  = 31;

    localparam logic [31:0] DEFAULT_HANDLER_ADDR = 32'h0000_4180;
    localparam logic [31:0] DEFAULT_PRID         = 32'h2017_0001;

    // SR.EXL is the mode bit: HANDLER blocks every further trap.
    typedef enum logic {
        MODE_NORMAL  = 1'b0,
        MODE_HANDLER = 1'b1
    } mode_e;

endpackage

// File: rtl/cp0_trap_arb.sv
// Combinational trap arbiter: decides whether an interrupt/exception or an
// eret is taken this cycle and which ExcCode gets recorded.
module cp0_trap_arb
    import cp0_pkg::*;
(
    input  logic       i_valid,
    input  logic       i_exception,
    input  logic [4:0] i_exc_code,
    input  logic       i_eret,
    input  logic [5:0] i_hwint,
    input  logic [5:0] i_im,
    input  logic       i_ie,
    input  logic       i_exl,
    output logic       o_int_req,
    output logic       o_eret_req,
    output logic [4:0] o_exc_code
);

    logic w_irq;
    logic w_exc;

    assign w_irq = (|(i_hwint & i_im)) & i_ie & ~i_exl;
    assign w_exc = i_exception & i_valid & ~i_exl;

    // Interrupts only ride on a real instruction so EPC always names one.
    assign o_int_req  = (w_irq & i_valid) | w_exc;
    assign o_eret_req = i_eret & ~o_int_req;
    assign o_exc_code = w_irq ? EXC_INT : i_exc_code;

endmodule

// File: rtl/cp0_exc_handler.sv
// CP0 exception/interrupt handler: SR/Cause/EPC/PRId register file, trap
// entry, eret return and mtc0/mfc0 access at the M stage.
module cp0_exc_handler
    import cp0_pkg::*;
#(
    parameter logic [31:0] HANDLER_ADDR = DEFAULT_HANDLER_ADDR,
    parameter logic [31:0] PRID         = DEFAULT_PRID
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ValidM,
    input  logic        ExceptionM,
    input  logic [4:0]  ExcM,
    input  logic [31:0] PCM,
    input  logic        BDM,
    input  logic        EretM,
    input  logic [5:0]  HWInt,
    input  logic        WE,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    output logic [31:0] DOut,
    output logic        IntReq,
    output logic        EretReq,
    output logic [31:0] RedirPC,
    output logic        EXLOut
);

    mode_e       r_mode;
    logic [5:0]  r_sr_im;
    logic        r_sr_ie;
    logic        r_cause_bd;
    logic [5:0]  r_cause_ip;
    logic [4:0]  r_cause_exc;
    logic [31:0] r_epc;

    mode_e       w_mode_next;
    logic        w_exl;
    logic        w_arb_int;
    logic        w_arb_eret;
    logic [4:0]  w_exc_code;
    logic        w_int_req;
    logic        w_eret_req;
    logic        w_mtc0;

    assign w_exl = (r_mode == MODE_HANDLER);

    cp0_trap_arb u_trap_arb (
        .i_valid    (ValidM),
        .i_exception(ExceptionM),
        .i_exc_code (ExcM),
        .i_eret     (EretM),
        .i_hwint    (HWInt),
        .i_im       (r_sr_im),
        .i_ie       (r_sr_ie),
        .i_exl      (w_exl),
        .o_int_req  (w_arb_int),
        .o_eret_req (w_arb_eret),
        .o_exc_code (w_exc_code)
    );

    // Reset dominates the combinational outputs, not just the state.
    assign w_int_req  = w_arb_int & ~reset;
    assign w_eret_req = w_arb_eret & ~reset;
    assign w_mtc0     = WE & ~w_int_req & ~w_eret_req & ~reset;

    always_comb begin
        // NOTE: default first so every path assigns w_mode_next (no latch).
        w_mode_next = r_mode;
        if (w_int_req)
            w_mode_next = MODE_HANDLER;
        else if (w_eret_req)
            w_mode_next = MODE_NORMAL;
        else if (w_mtc0 && (A2 == REG_SR))
            w_mode_next = DIn[SR_EXL_BIT] ? MODE_HANDLER : MODE_NORMAL;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode      <= MODE_NORMAL;
            r_sr_im     <= '0;
            r_sr_ie     <= 1'b0;
            r_cause_bd  <= 1'b0;
            r_cause_ip  <= '0;
            r_cause_exc <= '0;
            r_epc       <= '0;
        end else begin
            r_mode     <= w_mode_next;
            r_cause_ip <= HWInt;
            if (w_int_req) begin
                r_cause_exc <= w_exc_code;
                r_cause_bd  <= BDM;
                r_epc       <= BDM ? (PCM - 32'd4) : PCM;
            end else if (w_mtc0) begin
                if (A2 == REG_SR) begin
                    r_sr_im <= DIn[SR_IM_MSB:SR_IM_LSB];
                    r_sr_ie <= DIn[SR_IE_BIT];
                end
                if (A2 == REG_EPC)
                    r_epc <= DIn;
            end
        end
    end

    always_comb begin
        DOut = '0;
        case (A1)
            REG_SR: begin
                DOut[SR_IM_MSB:SR_IM_LSB] = r_sr_im;
                DOut[SR_EXL_BIT]          = w_exl;
                DOut[SR_IE_BIT]           = r_sr_ie;
            end
            REG_CAUSE: begin
                DOut[CAUSE_BD_BIT]                = r_cause_bd;
                DOut[CAUSE_IP_MSB:CAUSE_IP_LSB]   = r_cause_ip;
                DOut[CAUSE_EXC_MSB:CAUSE_EXC_LSB] = r_cause_exc;
            end
            REG_EPC:  DOut = r_epc;
            REG_PRID: DOut = PRID;
            default:  DOut = '0;
        endcase
    end

    assign IntReq  = w_int_req;
    assign EretReq = w_eret_req;
    assign RedirPC = w_int_req ? HANDLER_ADDR : (w_eret_req ? r_epc : 32'd0);
    assign EXLOut  = w_exl & ~reset;

endmodule

// File: doc/cp0_exc_handler.md
# cp0_exc_handler

Coprocessor-0 exception/interrupt handler for the five-stage MIPS pipeline; the consuming end of the E→M exception pipeline register. It samples the M-stage exception flag and ExcCode, merges them with external hardware interrupts, and decides whether to take a trap. When it takes one, it records SR/Cause/EPC, raises a flush request and supplies the redirect PC. It also services `mtc0`/`mfc0` and `eret`.

## Interface
- `HANDLER_ADDR`, default 32'h0000_4180: trap entry PC.
- `PRID`, default 32'h2017_0001: constant PRId contents.

- `clk` in 1: single clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `ValidM` in 1: M-stage holds a real instruction (not a bubble).
- `ExceptionM` in 1: M-stage instruction carries a synchronous exception.
- `ExcM` in 5: ExcCode of that exception (4 AdEL, 5 AdES, 10 RI, 12 Ov).
- `PCM` in 32: PC of M-stage instruction.
- `BDM` in 1: M-stage instruction sits in a branch delay slot.
- `EretM` in 1: M-stage instruction is `eret`.
- `HWInt` in 6: level-sensitive external interrupt lines.
- `WE` in 1: `mtc0` write enable (M stage).
- `A1` in 5: `mfc0` source register number.
- `A2` in 5: `mtc0` destination register number.
- `DIn` in 32: `mtc0` write data.
- `DOut` out 32: `mfc0` read data, combinational from `A1`.
- `IntReq` out 1: trap taken this cycle; flush F/D/E/M and redirect.
- `EretReq` out 1: `eret` taken this cycle; flush and redirect.
- `RedirPC` out 32: `HANDLER_ADDR` when `IntReq`, EPC when `EretReq`, else 0.
- `EXLOut` out 1: current SR.EXL.

## Operation
- **Registers.**
  - SR (12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
  - Cause (13): BD[31], IP[15:10], ExcCode[6:2]; other bits read 0. Software cannot write Cause.
  - EPC (14): full 32 bits.
  - PRId (15): `PRID`, read-only.
  - Any other `A1` returns 0. `mtc0` to any other register is ignored.
- **Cause.IP.** Loaded from `HWInt` every cycle while not in reset.
- **Interrupt pending.** `irq = |(HWInt & SR.IM) & SR.IE & ~SR.EXL`.
- **Exception pending.** `exc = ExceptionM & ValidM & ~SR.EXL`.
- **Take.** `IntReq = (irq & ValidM) | exc`.
  - Interrupts are taken only on a valid M-stage instruction, so EPC is always meaningful.
- **Priority.** Interrupt beats synchronous exception. When both are pending, ExcCode = 0.
- **On `IntReq` (next edge):**
  - SR.EXL ← 1.
  - Cause.ExcCode ← `irq ? 0 : ExcM`.
  - Cause.BD ← `BDM`.
  - EPC ← `BDM ? PCM-4 : PCM`.
  - The faulting/interrupted instruction must not commit.
- **On `EretM & ~IntReq`:**
  - `EretReq` = 1.
  - SR.EXL ← 0 at next edge.
  - `RedirPC` = current EPC register value.
- **Mode state.** Two states held in SR.EXL:
  - NORMAL (EXL=0) → HANDLER on `IntReq`.
  - HANDLER (EXL=1) → NORMAL on `eret` or on `mtc0` SR with DIn[1]=0.
  - While in HANDLER, no trap is taken, even with `ExceptionM` high.
- **`mtc0`.** Effective when `WE & ~IntReq`. A trap in the same cycle suppresses the write; the instruction is squashed.
- **Arithmetic.** PCM-4 is modulo 2^32. PCM is not realigned, so an AdEL-on-fetch records the misaligned PC.

## Timing
- **Reset values.** SR=0, Cause=0, EPC=0, `IntReq`=0, `EretReq`=0, `RedirPC`=0, `EXLOut`=0. All outputs are forced to these values in any cycle with `reset`=1, regardless of inputs.
- **Latency.** `IntReq`, `EretReq`, `RedirPC` and `DOut` are combinational in the M cycle. Register effects are visible from the following cycle.
- **`mfc0` reads.** Return pre-edge values; there is no write-through bypass. `mtc0` EPC followed by `eret` one cycle later redirects to the new EPC.
- **Simultaneous events.**
  - Trap beats `eret`, which beats `mtc0`.
  - `eret` with `mtc0` SR in the same cycle cannot occur (single M-stage instruction); no guarantee is given if it does.
- **Reset mid-handler.** Returns to NORMAL immediately; EPC is lost.

## Structure
- **Shared package `cp0_pkg`:**
  - Register numbers: SR=12, CAUSE=13, EPC=14, PRID=15.
  - ExcCode constants: INT=0, ADEL=4, ADES=5, RI=10, OV=12.
  - SR/Cause field bit positions.
  - Default `HANDLER_ADDR`.
- **Sub-module.** One natural sub-module, `cp0_trap_arb`: a combinational priority/take decision producing `IntReq`, `EretReq` and the selected ExcCode. The register file stays in the top module.

## Test plan
- **Reset.** Reset asserted with `ExceptionM`=1, `ExcM`=12 → `IntReq`=0 and all registers 0. After release, `DOut`(A1=12)=0.
- **Overflow trap.** `ExceptionM`=1, `ExcM`=12, `ValidM`=1, `PCM`=0x3010, `BDM`=0 → `IntReq`=1, `RedirPC`=0x4180. Next cycle: Cause=0x0000_0030, EPC=0x3010, EXL=1.
- **Delay-slot trap.** `ExcM`=4, `PCM`=0x3024, `BDM`=1 → EPC=0x3020 and Cause[31]=1. A second `ExceptionM` the following cycle gives `IntReq`=0.
- **Interrupt.** `mtc0` SR=0x0000_0401, then `HWInt`=6'b000001 with a valid M instruction → `IntReq`=1, ExcCode=0, Cause.IP=0x0400. With `HWInt`=6'b000010 instead, no take.
- **Eret.** In HANDLER: `mtc0` EPC=0x3100, next cycle `EretM`=1 → `EretReq`=1, `RedirPC`=0x3100. Next cycle EXL=0.
- **Simultaneous events.** `WE`=1 to EPC with DIn=0xDEAD and `ExceptionM`=1 in the same cycle → EPC holds PCM, not 0xDEAD. Interrupt and `ExcM`=10 together → ExcCode=0.
